vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Arbiter that shares one single-port 160x120x8 frame-buffer RAM between VGA scan-out reads and a drawing-engine write port. It sits between the VGA timing/colour block and the frame RAM. Scan-out owns every 4th pixel clock of the active region, so no pixel is ever missed. All remaining cycles go to an optional full-screen clear engine first, then to the writer.

## Interface
- FB_W, 160, frame-buffer width in pixels (each covers 4x4 screen pixels)
- FB_H, 120, frame-buffer height
- ADDR_W, 15, RAM address width (FB_W*FB_H = 19200 words)
- CLOCK_25  in  1  pixel clock; single clock domain
- reset  in  1  synchronous, active-high
- scan_active  in  1  high while next_x/next_y lie in the 640x480 visible area
- next_x  in  10  next screen column, 0..639
- next_y  in  10  next screen row, 0..479
- pix_color  out  8  RRRGGGBB colour for the VGA block
- wr_valid  in  1  writer request
- wr_ready  out  1  writer request accepted this cycle
- wr_x  in  8  frame-buffer column
- wr_y  in  7  frame-buffer row
- wr_color  in  8  pixel value to write
- clr_req  in  1  one-cycle clear command (only when FB_CLEAR_EN is defined)
- clr_color  in  8  fill value, sampled with clr_req
- clr_busy  out  1  clear in progress
- mem_addr  out  15  RAM address, registered
- mem_we  out  1  RAM write enable, registered
- mem_wdata  out  8  RAM write data, registered
- mem_rdata  in  8  RAM read data, valid one cycle after the read address is presented

## Operation
- Scan slot: scan_active && next_x[1:0]==0.
  - Issue a read at address (next_y>>2)*FB_W + (next_x>>2).
  - Compute y*160 as (y<<7)+(y<<5); no multiplier.
  - Scan slot has absolute priority and cannot be stalled.
- Clear engine.
  - States: IDLE and CLEAR.
  - IDLE -> CLEAR on clr_req: latch clr_color, set clr_cnt=0, set clr_busy=1.
  - In CLEAR, every non-scan cycle writes the latched colour to clr_cnt, then increments clr_cnt.
  - After writing address 19199: return to IDLE and set clr_busy=0.
  - clr_req while in CLEAR is ignored.
- Writer gets a cycle only when there is no scan slot and the state is IDLE.
  - wr_ready is combinational: !scan_slot && state==IDLE.
  - Transfer occurs when wr_valid && wr_ready.
  - In-range transfer: write wr_color to wr_y*160+wr_x.
  - wr_x>=160 or wr_y>=120: the transfer still completes (wr_ready asserts) but mem_we stays 0; the request is dropped silently.
- Idle cycles (nothing granted): mem_we=0; mem_addr holds its previous value.
- pix_color captures mem_rdata only for a scan read and holds between slots.
- Outside the active region, pix_color is forced to 0 on the cycle the read would have returned.

## Timing
- Reset values: pix_color=0, mem_we=0, mem_addr=0, mem_wdata=0, clr_busy=0, state=IDLE, clr_cnt=0.
- Scan slot at cycle t:
  - mem_addr is valid at t+1.
  - mem_rdata is valid at t+2.
  - pix_color is updated at the end of t+2.
  - Fixed latency: 2 cycles from slot to pix_color. The VGA block compensates by driving next_x two pixels early.
- Write granted at cycle t: mem_we/mem_addr/mem_wdata are asserted during t+1 for exactly one cycle.
- Back-to-back writes: maximum 3 per 4 cycles during the active region, 1 per cycle during blanking.
- Full clear:
  - During blanking: 19200 cycles.
  - During the active region: 3/4 throughput.
- clr_req on the same cycle as wr_valid: the clear wins from the next cycle. The writer is granted that cycle only if wr_ready was already high (state was IDLE).
- Reset mid-clear: aborts immediately. The partially cleared RAM is left as is; clr_busy=0 on the next cycle.

## Configuration
- FB_CLEAR_EN defined: clear engine, clr_req/clr_color/clr_busy ports and CLEAR state are present.
- FB_CLEAR_EN undefined:
  - Ports remain; clr_req and clr_color are ignored.
  - clr_busy is tied to 0.
  - The state machine reduces to IDLE only.
  - Writer arbitration depends only on scan_slot.

## Structure
- Package vga_fb_pkg holds:
  - FB_W, FB_H, FB_DEPTH=19200, ADDR_W, COLOR_W=8
  - the state enum (IDLE, CLEAR)
  - the RRRGGGBB field positions
- Sub-module vga_fb_addr: combinational (x,y) -> {addr, in_range}. It is used by both the scan and write paths; its in_range output is ignored for scan.

## Test plan
- Reset with wr_valid=1 -> all outputs 0 for the reset cycle; wr_ready follows scan_slot after release.
- Write (x=5, y=3, color=0xE0) during blanking -> next cycle mem_we=1, mem_addr=485, mem_wdata=0xE0; model RAM word 485 = 0xE0.
- Scan with next_x=20, next_y=12, RAM[3*160+5]=0x1C -> mem_addr=485 at t+1, pix_color=0x1C at t+2; wr_ready=0 at t.
- Continuous wr_valid over 400 active cycles -> exactly 300 accepted, none on slot cycles, zero missed scan reads.
- Write to x=160, y=0 -> wr_ready=1, mem_we stays 0, RAM unchanged.
- (FB_CLEAR_EN) clr_req with clr_color=0x03 in blanking -> clr_busy high for 19200 cycles, all words 0x03, wr_ready=0 throughout; reset asserted at cycle 100 -> clr_busy=0 the next cycle, words 0..98 = 0x03.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared constants and types for the frame-buffer arbiter.
// Frame buffer is 160x120 words of RRRGGGBB colour, one word per 4x4 screen block.
package vga_fb_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;   // 19200 words
  localparam int ADDR_W   = 15;
  localparam int COLOR_W  = 8;
  localparam int X_W      = 8;             // frame-buffer column width
  localparam int Y_W      = 7;             // frame-buffer row width

  // RRRGGGBB field positions
  localparam int RED_MSB = 7;
  localparam int RED_LSB = 5;
  localparam int GRN_MSB = 4;
  localparam int GRN_LSB = 2;
  localparam int BLU_MSB = 1;
  localparam int BLU_LSB = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  // One RAM command as presented on the registered memory port
  typedef struct packed {
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/vga_fb_addr.sv
// vga_fb_addr: (x,y) -> linear frame-buffer address plus range flag.
// y*160 is built as (y<<7)+(y<<5) so no multiplier is inferred.
module vga_fb_addr
  import vga_fb_pkg::*;
(
  input  logic [X_W-1:0]    x_i,
  input  logic [Y_W-1:0]    y_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              in_range_o
);

  logic [ADDR_W-1:0] x_ext, y_ext;

  assign x_ext      = ADDR_W'(x_i);
  assign y_ext      = ADDR_W'(y_i);
  assign addr_o     = (y_ext << 7) + (y_ext << 5) + x_ext;
  assign in_range_o = (x_i < X_W'(FB_W)) && (y_i < Y_W'(FB_H));

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port frame RAM between VGA scan-out and a
// drawing writer. Scan-out owns every 4th active pixel clock; remaining cycles
// go to the clear engine (when built), then to the writer.
// Build option: define FB_CLEAR_EN to include the full-screen clear engine.
module vga_fb_arbiter
  import vga_fb_pkg::*;
(
  input  logic               CLOCK_25,
  input  logic               reset,
  input  logic               scan_active,
  input  logic [9:0]         next_x,
  input  logic [9:0]         next_y,
  output logic [COLOR_W-1:0] pix_color,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [X_W-1:0]     wr_x,
  input  logic [Y_W-1:0]     wr_y,
  input  logic [COLOR_W-1:0] wr_color,
  input  logic               clr_req,
  input  logic [COLOR_W-1:0] clr_color,
  output logic               clr_busy,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata
);

  // slot -> address registered -> data back from RAM
  localparam int STAGES = 2;

  logic               scan_slot;
  logic [ADDR_W-1:0]  scan_addr, wr_addr;
  logic               scan_rng_unused, wr_in_range;
  logic [2:0]         ny_unused;
  fb_state_e          state_q;
  mem_req_t           req_q, req_d;
  logic [STAGES-1:0]  slot_pipe_q, act_pipe_q;
  logic [COLOR_W-1:0] pix_q;

  assign scan_slot = scan_active && (next_x[1:0] == 2'b00);
  // Row bits below the 4x block and the top bit (rows >= 512) never address RAM
  assign ny_unused = {next_y[9], next_y[1:0]};

  vga_fb_addr u_scan_addr (
    .x_i        (next_x[9:2]),
    .y_i        (next_y[8:2]),
    .addr_o     (scan_addr),
    .in_range_o (scan_rng_unused)
  );

  vga_fb_addr u_wr_addr (
    .x_i        (wr_x),
    .y_i        (wr_y),
    .addr_o     (wr_addr),
    .in_range_o (wr_in_range)
  );

`ifdef FB_CLEAR_EN
  fb_state_e          state_d;
  logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [COLOR_W-1:0] clr_col_q, clr_col_d;

  // Clear-engine state, fill pointer and latched fill colour
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      clr_col_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      clr_col_q <= clr_col_d;
    end
  end

  // Start on clr_req from IDLE; in CLEAR advance on every cycle scan-out leaves free
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_col_d = clr_col_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          clr_col_d = clr_color;
        end
      end
      CLEAR: begin
        if (!scan_slot) begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == ADDR_W'(FB_DEPTH - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_busy = (state_q == CLEAR);
`else
  logic [COLOR_W:0] clr_unused;

  assign clr_unused = {clr_req, clr_color};
  assign state_q    = IDLE;
  assign clr_busy   = 1'b0;
`endif

  // Slot arbitration: scan read first, then clear fill, then writer; idle holds addr
  always_comb begin
    req_d    = req_q;
    req_d.we = 1'b0;
    wr_ready = !scan_slot && (state_q == IDLE);
    if (scan_slot) begin
      req_d.addr = scan_addr;
    end
`ifdef FB_CLEAR_EN
    else if (state_q == CLEAR) begin
      req_d.we    = 1'b1;
      req_d.addr  = clr_cnt_q;
      req_d.wdata = clr_col_q;
    end
`endif
    else if (wr_valid && wr_ready && wr_in_range) begin
      req_d.we    = 1'b1;
      req_d.addr  = wr_addr;
      req_d.wdata = wr_color;
    end
  end

  // Registered RAM command port
  always_ff @(posedge CLOCK_25) begin
    if (reset) req_q <= '0;
    else       req_q <= req_d;
  end

  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;

  // Track slot/active flags alongside the RAM latency and capture the read colour
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      slot_pipe_q <= '0;
      act_pipe_q  <= '0;
      pix_q       <= '0;
    end else begin
      slot_pipe_q <= {slot_pipe_q[STAGES-2:0], scan_slot};
      act_pipe_q  <= {act_pipe_q[STAGES-2:0], scan_active};
      if (!act_pipe_q[STAGES-1])      pix_q <= '0;
      else if (slot_pipe_q[STAGES-1]) pix_q <= mem_rdata;
    end
  end

  assign pix_color = pix_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: randomized + directed bench with a behavioural frame-buffer
// model feeding expectation queues; an independent monitor pops and compares.
module tb_vga_fb_arbiter;

  localparam int FBD   = 19200;
  localparam int RAM_N = 32768;

  logic       clk;
  logic       reset;
  logic       scan_active;
  logic [9:0] next_x, next_y;
  logic [7:0] pix_color;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  logic [7:0] wr_color;
  logic       clr_req;
  logic [7:0] clr_color;
  logic       clr_busy;
  logic [14:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] ram [0:RAM_N-1];
  logic       fill;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit run = 0;
  bit mon_en = 0;
  int scan_seen = 0;
  int accepted = 0;

  typedef struct { int cyc; bit we; int addr; int data; } mem_exp_t;
  typedef struct { int due; int val; } pix_exp_t;
  mem_exp_t mq[$];
  pix_exp_t pq[$];
  int ref_fb [0:FBD-1];

  vga_fb_arbiter dut (
    .CLOCK_25    (clk),
    .reset       (reset),
    .scan_active (scan_active),
    .next_x      (next_x),
    .next_y      (next_y),
    .pix_color   (pix_color),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_color    (wr_color),
    .clr_req     (clr_req),
    .clr_color   (clr_color),
    .clr_busy    (clr_busy),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM, registered read
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < RAM_N; i++) ram[i] <= init_val(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: decide grants from the arbitration rules, keep a frame image
  int  m_addr, m_v, m_last;
  bit  m_slot;
  initial begin
    for (int i = 0; i < FBD; i++) ref_fb[i] = int'(init_val(i));
    m_last = 0;
    forever begin
      @(negedge clk);
      if (run) begin
        m_slot = scan_active && (int'(next_x) % 4 == 0);
        chk("wr_ready", int'(wr_ready), int'(!m_slot));
        if (m_slot) begin
          m_addr = (int'(next_y) / 4) * 160 + int'(next_x) / 4;
          mq.push_back('{cyc, 1'b0, m_addr, 0});
        end else if (wr_valid) begin
          accepted++;
          if (int'(wr_x) < 160 && int'(wr_y) < 120) begin
            m_addr = int'(wr_y) * 160 + int'(wr_x);
            ref_fb[m_addr] = int'(wr_color);
            mq.push_back('{cyc, 1'b1, m_addr, int'(wr_color)});
          end
        end
        if (!scan_active) m_v = 0;
        else if (m_slot)  m_v = ref_fb[(int'(next_y) / 4) * 160 + int'(next_x) / 4];
        else              m_v = m_last;
        m_last = m_v;
        pq.push_back('{cyc + 3, m_v});
      end
    end
  end

  // Monitor: compare RAM port and pixel output against queued expectations
  mem_exp_t me;
  pix_exp_t pe;
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      while (mq.size() > 0 && mq[0].cyc < cyc - 1) begin
        me = mq.pop_front();
        chk("mem_stale", 1, 0);
      end
      if (mq.size() > 0 && mq[0].cyc == cyc - 1) begin
        me = mq.pop_front();
        if (me.we) begin
          chk("mem_write", int'({mem_we, mem_addr, mem_wdata}),
              int'({1'b1, 15'(me.addr), 8'(me.data)}));
        end else begin
          chk("scan_read", int'({mem_we, mem_addr}), int'({1'b0, 15'(me.addr)}));
          if (!mem_we && mem_addr == 15'(me.addr)) scan_seen++;
        end
      end else begin
        chk("mem_idle_we", int'(mem_we), 0);
      end
      while (pq.size() > 0 && pq[0].due < cyc) begin
        pe = pq.pop_front();
        chk("pix_stale", 1, 0);
      end
      if (pq.size() > 0 && pq[0].due == cyc) begin
        pe = pq.pop_front();
        chk("pix_color", int'(pix_color), pe.val);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    scan_active = 1'b0;
    wr_valid    = 1'b0;
    clr_req     = 1'b0;
  endtask

  int len, bx, by, acc0, seen0, old, nbad, nb, na;
  bit act, done;

  initial begin
    reset = 1'b1; fill = 1'b1;
    scan_active = 1'b0; next_x = '0; next_y = '0;
    wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd3; wr_color = 8'hAA;
    clr_req = 1'b0; clr_color = 8'h00;
    tick(); fill = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_pix", int'(pix_color), 0);
    chk("rst_mem", int'({mem_we, mem_addr, mem_wdata}), 0);
    chk("rst_busy", int'(clr_busy), 0);
    tick();
    reset = 1'b0; idle(); run = 1'b1; mon_en = 1'b1;
    tick(); tick(); tick();

    // Write in blanking
    wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd3; wr_color = 8'hE0;
    tick(); idle(); tick();
    chk("ram_485_e0", int'(ram[485]), 8'hE0);

    // Scan read of a freshly written word; writer refused on the slot
    wr_valid = 1'b1; wr_color = 8'h1C;
    tick(); idle(); tick();
    scan_active = 1'b1; next_x = 10'd20; next_y = 10'd12;
    wr_valid = 1'b1; wr_x = 8'd9; wr_y = 7'd9; wr_color = 8'h77;
    @(negedge clk);
    chk("slot_wr_ready", int'(wr_ready), 0);
    tick(); wr_valid = 1'b0; next_x = 10'd21;
    tick(); next_x = 10'd22;
    tick(); next_x = 10'd23;
    @(negedge clk);
    chk("slot_pix_1c", int'(pix_color), 8'h1C);
    tick(); idle(); tick();

    // Continuous writer over 400 active cycles
    acc0 = accepted; seen0 = scan_seen;
    for (int i = 0; i < 400; i++) begin
      scan_active = 1'b1; next_x = 10'(i); next_y = 10'($urandom_range(0, 23));
      wr_valid = 1'b1; wr_x = 8'($urandom_range(0, 11)); wr_y = 7'($urandom_range(0, 6));
      wr_color = 8'($urandom);
      tick();
    end
    idle(); tick(); tick();
    chk("active_accepts", accepted - acc0, 300);
    chk("active_scan_reads", scan_seen - seen0, 100);

    // Out-of-range write completes but is dropped
    old = int'(ram[160]);
    wr_valid = 1'b1; wr_x = 8'd160; wr_y = 7'd0; wr_color = 8'h5A;
    @(negedge clk);
    chk("oor_wr_ready", int'(wr_ready), 1);
    tick(); idle(); tick(); tick();
    chk("oor_ram_160", int'(ram[160]), old);

`ifndef FB_CLEAR_EN
    // Clear command ignored in this build
    clr_req = 1'b1; clr_color = 8'h03;
    wr_valid = 1'b1; wr_x = 8'd1; wr_y = 7'd1; wr_color = 8'h42;
    tick(); idle();
    @(negedge clk);
    chk("noclr_busy", int'(clr_busy), 0);
    chk("noclr_ready", int'(wr_ready), 1);
    tick();
`endif

    // Randomized traffic
    for (int s = 0; s < 60; s++) begin
      len = $urandom_range(8, 64);
      act = 1'($urandom_range(0, 1));
      bx  = $urandom_range(0, 40);
      by  = $urandom_range(0, 23);
      for (int k = 0; k < len; k++) begin
        scan_active = act; next_x = 10'(bx + k); next_y = 10'(by);
        wr_valid = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 7) == 0) begin
          wr_x = 8'($urandom_range(150, 255)); wr_y = 7'($urandom_range(0, 127));
        end else begin
          wr_x = 8'($urandom_range(0, 11)); wr_y = 7'($urandom_range(0, 6));
        end
        wr_color = 8'($urandom);
        tick();
      end
    end

    idle();
    repeat (5) tick();
    run = 1'b0;
    repeat (4) tick();
    chk("sb_drain", mq.size() + pq.size(), 0);
    mon_en = 1'b0;

`ifdef FB_CLEAR_EN
    // Reset part-way through a clear
    idle(); clr_req = 1'b1; clr_color = 8'h03;
    tick(); clr_req = 1'b0;
    repeat (99) tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("abort_busy", int'(clr_busy), 0);
    chk("abort_we", int'(mem_we), 0);
    reset = 1'b0;
    tick(); tick();
    nbad = 0;
    for (int i = 0; i < 99; i++) if (ram[i] !== 8'h03) nbad++;
    chk("partial_clear_words", nbad, 0);
    chk("partial_clear_edge", int'(ram[99]), ref_fb[99]);

    // Full clear in blanking with the writer hammering (off-screen target)
    wr_valid = 1'b1; wr_x = 8'd200; wr_y = 7'd0; wr_color = 8'hFF;
    clr_req = 1'b1; clr_color = 8'h03;
    tick(); clr_req = 1'b0;
    nb = 0; na = 0; done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clk);
      if (!clr_busy) done = 1'b1;
      else begin
        nb++;
        if (wr_ready) na++;
        tick();
      end
    end
    chk("clear_done", int'(done), 1);
    chk("clear_cycles", nb, 19200);
    chk("clear_wr_ready", na, 0);
    idle(); tick(); tick();
    nbad = 0;
    for (int i = 0; i < FBD; i++) if (ram[i] !== 8'h03) nbad++;
    chk("clear_words", nbad, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
